// File: rtl/fp_div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package fp_div_pkg;

  localparam int unsigned DIV_ITER    = 48;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/fp_div_sched_rr_arb2.sv
// Two-way round-robin grant; the last-grant history lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      // On a tie, favour whoever was not served most recently.
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/fp_div_sched.sv
// Schedules two requesters onto one iterative FP divider and returns results.
module fp_div_sched
  import fp_div_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = 7
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_ovf,
  output logic         rsp_unf,
  output logic         rsp_err,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_load_n,
  input  logic [W-1:0] div_result,
  input  logic         div_ovf,
  input  logic         div_unf,
  input  logic         div_done
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_comb begin
    req0_ready = (state == S_IDLE) & gnt[0];
    req1_ready = (state == S_IDLE) & gnt[1];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp_unf    <= 1'b0;
      rsp_err    <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_load_n <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            div_a      <= gnt[1] ? req1_a : req0_a;
            div_b      <= gnt[1] ? req1_b : req0_b;
            rsp_id     <= gnt[1];
            last_grant <= gnt[1];
            div_load_n <= 1'b0;
            state      <= S_LOAD;
          end else begin
            div_load_n <= 1'b1;
          end
        end
        S_LOAD: begin
          div_load_n <= 1'b1;
          cnt        <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          // A done seen in the first RUN cycle belongs to the previous operation.
          if (div_done && (cnt != '0)) begin
            rsp_result <= div_result;
            rsp_ovf    <= div_ovf;
            rsp_unf    <= div_unf;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_unf    <= 1'b0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_sched.sv
// Self-checking bench for fp_div_sched with a behavioural divider stub and scheduler model.
module tb_fp_div_sched;
  import fp_div_pkg::*;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_ovf, rsp_unf, rsp_err;
  logic [31:0] rsp_result, div_a, div_b, div_result;
  logic        div_load_n, div_ovf, div_unf, div_done;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  fp_div_sched #(.W(32), .TIMEOUT(TO), .CW(7)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_err(rsp_err),
    .div_a(div_a), .div_b(div_b), .div_load_n(div_load_n),
    .div_result(div_result), .div_ovf(div_ovf), .div_unf(div_unf), .div_done(div_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub: quotient table, done after DIV_ITER cycles out of load.
  // mode 0 = normal, 1 = done stuck low, 2 = done stuck high.
  int unsigned it = 0;
  int unsigned mode = 0;

  function automatic logic [33:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40400000, 32'h40000000}: return {2'b00, 32'h3FC00000};
      {32'h3F800000, 32'h40800000}: return {2'b00, 32'h3E800000};
      {32'h40C00000, 32'h40400000}: return {2'b00, 32'h40000000};
      {32'h41200000, 32'h40800000}: return {2'b00, 32'h40200000};
      {32'h7F000000, 32'h3E800000}: return {2'b10, 32'h7F800000};
      {32'h00800000, 32'h41000000}: return {2'b01, 32'h00000000};
      default:                      return {2'b00, 32'hDEADBEEF};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!div_load_n) it <= DIV_ITER;
    else if (it != 0) it <= it - 1;
  end

  always_comb begin
    {div_ovf, div_unf, div_result} = div_ref(div_a, div_b);
    div_done = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (it == 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scheduler model: accept times, expected latency and held response fields.
  logic        m_busy = 1'b0, m_last = 1'b1, m_load_n = 1'b0, m_id = 1'b0;
  int unsigned m_acc = 0, m_lat = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0, p_res = '0;
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_err = 1'b0, p_ovf, p_unf, p_err;

  always @(negedge clk) begin
    logic ev, r0, r1;
    logic [33:0] q;
    if (!n_rst) begin
      chk("reset_outputs",
          {rsp_valid, rsp_id, rsp_ovf, rsp_unf, rsp_err, rsp_result, div_load_n, div_a, div_b},
          '0);
      m_busy = 1'b0; m_last = 1'b1; m_load_n = 1'b0; m_id = 1'b0;
      m_a = '0; m_b = '0; m_res = '0; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    end else begin
      ev = m_busy && (cyc >= m_acc + m_lat);
      if (ev) begin
        m_res = p_res; m_ovf = p_ovf; m_unf = p_unf; m_err = p_err;
      end
      r0 = !m_busy && req0_valid && (!req1_valid || m_last);
      r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      chk("rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_unf, rsp_err, rsp_result},
          {ev, m_id, m_ovf, m_unf, m_err, m_res});
      chk("div_ops", {div_a, div_b}, {m_a, m_b});
      chk("div_load_n", div_load_n, m_load_n);
      chk("ready", {req1_ready, req0_ready}, {r1, r0});
      m_load_n = !(r0 || r1);
      if (ev && rsp_ready) m_busy = 1'b0;
      if (r0 || r1) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_id   = r1;
        m_last = r1;
        m_a    = r1 ? req1_a : req0_a;
        m_b    = r1 ? req1_b : req0_b;
        q      = div_ref(m_a, m_b);
        if (mode == 1) begin
          m_lat = 2 + TO; p_res = '0; p_ovf = 1'b0; p_unf = 1'b0; p_err = 1'b1;
        end else begin
          m_lat = (mode == 2) ? 4 : 51;
          {p_ovf, p_unf, p_res} = q; p_err = 1'b0;
        end
      end
    end
  end

  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                      output int unsigned acc);
    bit ok;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; acc = cyc; break; end
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d never got ready", id);
    end
  endtask

  task automatic wait_rsp(output int unsigned rc);
    bit ok;
    ok = 1'b0;
    rc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; rc = cyc; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid never rose");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  initial begin
    int unsigned acc, rc, rel, n;
    int unsigned ac [4];
    logic [3:0] gs;
    int unsigned r1_seen;

    #2 n_rst = 1'b0;
    @(negedge clk);
    chk("reset_load_n", div_load_n, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // A: single 3.0/2.0 request
    send(1'b0, 32'h40400000, 32'h40000000, acc);
    wait_rsp(rc);
    chk("A_latency", rc - acc, 51);
    chk("A_result", rsp_result, 32'h3FC00000);
    chk("A_id_err", {rsp_id, rsp_err}, 2'b00);
    repeat (2) @(posedge clk);

    // B: both requesters continuously valid
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'h40C00000; req0_b = 32'h40400000;
    req1_valid = 1'b1; req1_a = 32'h41200000; req1_b = 32'h40800000;
    n = 0; gs = '0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gs[n] = req1_ready;
        ac[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("B_grants_seen", n, 4);
    chk("B_grant_order", gs, 4'b1010);
    chk("B_spacing", {ac[1] - ac[0], ac[2] - ac[1], ac[3] - ac[2]}, {32'd52, 32'd52, 32'd52});
    wait_rsp(rc);
    chk("B_last_result", {rsp_id, rsp_result}, {1'b1, 32'h40200000});
    repeat (2) @(posedge clk);

    // C: response back-pressure with req1 pending
    rsp_ready = 1'b0;
    send(1'b0, 32'h3F800000, 32'h40800000, acc);
    req1_valid = 1'b1; req1_a = 32'h41200000; req1_b = 32'h40800000;
    wait_rsp(rc);
    r1_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (req1_ready) r1_seen++;
    end
    chk("C_no_accept_while_held", r1_seen, 0);
    chk("C_held_rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'h3E800000});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    rel = cyc;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready) begin n = cyc; break; end
    end
    chk("C_accept_after_release", n, rel + 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(rc);
    chk("C_req1_result", {rsp_id, rsp_result, rsp_err}, {1'b1, 32'h40200000, 1'b0});
    repeat (2) @(posedge clk);

    // Overflow and underflow flags pass through
    send(1'b0, 32'h7F000000, 32'h3E800000, acc);
    wait_rsp(rc);
    chk("ovf_rsp", {rsp_ovf, rsp_unf, rsp_result}, {2'b10, 32'h7F800000});
    repeat (2) @(posedge clk);

    // D: divider stalled -> timeout
    mode = 1;
    send(1'b0, 32'h40400000, 32'h40000000, acc);
    wait_rsp(rc);
    chk("D_latency", rc - acc, 2 + TO);
    chk("D_err_result", {rsp_err, rsp_ovf, rsp_unf, rsp_result}, {3'b100, 32'h0});
    repeat (2) @(posedge clk);
    mode = 0;

    // E: done stuck high -> capture at the second RUN cycle
    mode = 2;
    send(1'b1, 32'h00800000, 32'h41000000, acc);
    wait_rsp(rc);
    chk("E_latency", rc - acc, 4);
    chk("E_unf_rsp", {rsp_id, rsp_unf, rsp_err, rsp_result}, {3'b110, 32'h0});
    repeat (2) @(posedge clk);
    mode = 0;

    // F: reset during RUN, then a fresh req1
    send(1'b0, 32'h40C00000, 32'h40400000, acc);
    while (cyc < acc + 22) begin
      @(posedge clk); #1;
    end
    n_rst = 1'b0;
    @(negedge clk);
    chk("F_abort", {rsp_valid, div_load_n, div_a}, {2'b00, 32'h0});
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    send(1'b1, 32'h41200000, 32'h40800000, acc);
    wait_rsp(rc);
    chk("F_latency", rc - acc, 51);
    chk("F_result", {rsp_id, rsp_err, rsp_result}, {2'b10, 32'h40200000});
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
